invaes_spi_frontend: RTL
========================

// Module: invaes_spi_frontend
// PURPOSE
//   Single-clock SPI slave front-end that sits directly upstream of the inverse-AES core.
//   - Shift in: cyphertext then key, MSB first.
//   - Core side: issues a start pulse, waits for the core's done.
//   - Shift out: the 128-bit plaintext on sdo, with a host-visible done flag.
//   The asynchronous SPI pins are oversampled in the clk domain; no logic is clocked by sck.
// PARAMETERS
//   K            256  key width in bits; legal values 128, 192, 256
//   SYNC_STAGES  2    flip-flop depth of the sck/sdi/load synchronisers (>=2)
// PORTS
//   clk             in   1      system clock; all state changes on posedge
//   reset           in   1      asynchronous, active-high reset
//   sck             in   1      SPI clock from host, asynchronous to clk
//   sdi             in   1      SPI data in, sampled on sck rising edge
//   load            in   1      host frame strobe: high during shift-in
//   sdo             out  1      SPI data out, changes after sck falling edge
//   done            out  1      plaintext ready for shift-out
//   frame_err       out  1      one-cycle pulse: frame length != K+128 at load fall
//   core_start      out  1      one-cycle start pulse to inverse-AES core
//   core_cyphertext out  128    cyphertext to core, stable from core_start until core_done
//   core_key        out  K      key to core, stable from core_start until core_done
//   core_plaintext  in   128    result from core, valid when core_done=1
//   core_done       in   1      core completion; level or pulse, sampled each clk
// BEHAVIOUR
//   Reset values: sdo=0, done=0, frame_err=0, core_start=0, core_cyphertext=0, core_key=0,
//   state=IDLE, bit counter=0.
//   Sync: sck, sdi and load each pass SYNC_STAGES flops.
//   Edge detect: rise/fall of synced sck/load is valid SYNC_STAGES+1 clks after the pin edge.
//   sck timing requirement: high and low phases each >= SYNC_STAGES+1 clk periods.
//   Frame: bit 0 is cyphertext[127] and bit 127 is cyphertext[0]; bits 128..K+127 carry key[K-1] down to key[0].
//   Shift register: {ct,key} shifts left; synced sdi enters at the LSB on each detected sck rise.
//   Bit counter: $clog2(K+129) bits; saturates at K+128.
//   A rise seen at count K+128 sets an overflow flag and does not shift.
//   States:
//   - IDLE: load rise -> SHIFT_IN; counter and overflow cleared.
//   - SHIFT_IN: shift on each sck rise. On load fall:
//     count==K+128 && !overflow -> START; otherwise pulse frame_err -> IDLE.
//   - START: the shift register has already been copied to core_cyphertext/core_key on the transition into START.
//     core_start=1 for exactly one clk -> WAIT_CORE.
//   - WAIT_CORE: load edges and sck are ignored. On core_done:
//     core_plaintext -> output reg, done=1, sdo=plaintext[127], out counter=0 -> SHIFT_OUT.
//   - SHIFT_OUT: each detected sck fall shifts the output reg left and updates sdo to the next bit.
//     After 128 falls sdo=0; done stays 1.
//     On load rise: done=0, sdo=0 -> SHIFT_IN (new frame, abort allowed mid-output).
//   - SHIFT_OUT extra sck falls beyond 128: sdo holds 0, no wrap.
//   Simultaneous sck and load edges in the same clk: the load edge wins; that sck edge is dropped.
//   Reset is asynchronous and valid in any state; it returns every output to its reset value, even mid-frame.
//   Latency (load-fall pin edge to core_start): SYNC_STAGES+2 clks.
// STRUCTURE
//   Shared package aes_pkg holds:
//   - typedef enum {IDLE, SHIFT_IN, START, WAIT_CORE, SHIFT_OUT} spi_state_t
//   - localparam BLOCK_BITS=128
//   - function frame_bits(K) = K+128
//   Sub-module spi_edge_sync provides the synchroniser plus rise/fall detect.
//   It is instantiated for sck and load; sdi uses the sync chain only.
// TESTING
//   1. K=256, ct=8ea2b7ca516745bfeafc49904b496089, key=000102..1f; core model returns 00112233445566778899aabbccddeeff
//      -> core_key/core_cyphertext match the inputs, exactly one core_start, done=1, sdo stream equals the core result.
//   2. K=128, ct=3925841d02dc09fbdc118597196a0b32, key=2b7e151628aed2a6abf7158809cf4f3c; core model returns 3243f6a8885a308d313198a2e0370734
//      -> 128 sdo bits equal that value, MSB first.
//   3. Short frame of K+127 bits then load fall
//      -> frame_err 1-clk pulse, no core_start, state IDLE, done=0.
//   4. Long frame of K+130 bits
//      -> frame_err pulse, core_key unchanged from its previous value.
//   5. Reset asserted after 50 shifted bits, then a full valid frame
//      -> all outputs 0 during reset; second frame completes correctly.
//   6. Load rise after 40 output bits
//      -> done=0 within SYNC_STAGES+2 clks; next frame processed with a fresh result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the inverse-AES SPI front-end.
package aes_pkg;

    localparam int BLOCK_BITS = 128;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        START,
        WAIT_CORE,
        SHIFT_OUT
    } spi_state_t;

    // Total number of SPI bits in one frame: cyphertext block followed by the key.
    function automatic int frame_bits(input int k);
        return k + BLOCK_BITS;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings an asynchronous pin into the clk domain and flags its rising and
// falling edges. The edge flags are registered, so each one is a single-clk
// pulse that appears SYNC_STAGES+1 clocks after the pin changes.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchroniser chain, a delayed copy of its last stage, and the edge flags derived from both.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
            rise_q  <= chain_q[SYNC_STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/invaes_spi_frontend.sv
// SPI slave front-end for the inverse-AES core. The host shifts in
// cyphertext then key (MSB first) while load is high; a correct-length
// frame starts the core, and the plaintext is shifted back out on sdo.
// Every pin is oversampled in the clk domain; nothing runs on sck.
module invaes_spi_frontend
    import aes_pkg::*;
#(
    parameter int K           = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sck_i,
    input  logic                  sdi_i,
    input  logic                  load_i,
    output logic                  sdo_o,
    output logic                  done_o,
    output logic                  frame_err_o,
    output logic                  core_start_o,
    output logic [BLOCK_BITS-1:0] core_cyphertext_o,
    output logic [K-1:0]          core_key_o,
    input  logic [BLOCK_BITS-1:0] core_plaintext_i,
    input  logic                  core_done_i
);

    localparam int            FRAME     = frame_bits(K);
    localparam int            CW        = $clog2(K + 129);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME);

    logic sckRise;
    logic sckFall;
    logic loadRise;
    logic loadFall;

    logic [SYNC_STAGES-1:0] sdiSync_q;
    logic [FRAME-1:0]       shift_d;

    spi_state_t            state_q;
    logic [FRAME-1:0]      shift_q;
    logic [CW-1:0]         bitCnt_q;
    logic                  overflow_q;
    logic [BLOCK_BITS-2:0] outReg_q;
    logic [7:0]            outCnt_q;
    logic                  sdo_q;
    logic                  done_q;
    logic                  frameErr_q;
    logic                  coreStart_q;
    logic [BLOCK_BITS-1:0] coreCt_q;
    logic [K-1:0]          coreKey_q;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (sck_i),
        .rise_o  (sckRise),
        .fall_o  (sckFall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (load_i),
        .rise_o  (loadRise),
        .fall_o  (loadFall)
    );

    // sdi only needs the plain synchroniser; it is sampled when the sck rise flag fires.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sdiSync_q <= '0;
        end else begin
            sdiSync_q <= {sdiSync_q[SYNC_STAGES-2:0], sdi_i};
        end
    end

    assign shift_d = {shift_q[FRAME-2:0], sdiSync_q[SYNC_STAGES-1]};

    // Frame state machine; load edges are tested before sck edges so a load edge always wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            overflow_q  <= 1'b0;
            outReg_q    <= '0;
            outCnt_q    <= '0;
            sdo_q       <= 1'b0;
            done_q      <= 1'b0;
            frameErr_q  <= 1'b0;
            coreStart_q <= 1'b0;
            coreCt_q    <= '0;
            coreKey_q   <= '0;
        end else begin
            frameErr_q  <= 1'b0;
            coreStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (loadRise) begin
                        bitCnt_q   <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (loadFall) begin
                        if (bitCnt_q == FRAME_CNT && !overflow_q) begin
                            coreCt_q    <= shift_q[FRAME-1 -: BLOCK_BITS];
                            coreKey_q   <= shift_q[K-1:0];
                            coreStart_q <= 1'b1;
                            state_q     <= START;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end else if (sckRise) begin
                        if (bitCnt_q == FRAME_CNT) begin
                            overflow_q <= 1'b1;
                        end else begin
                            shift_q  <= shift_d;
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                end
                START: begin
                    state_q <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done_i) begin
                        outReg_q <= core_plaintext_i[BLOCK_BITS-2:0];
                        sdo_q    <= core_plaintext_i[BLOCK_BITS-1];
                        done_q   <= 1'b1;
                        outCnt_q <= '0;
                        state_q  <= SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (loadRise) begin
                        done_q     <= 1'b0;
                        sdo_q      <= 1'b0;
                        bitCnt_q   <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= SHIFT_IN;
                    end else if (sckFall) begin
                        if (outCnt_q < 8'd128) begin
                            sdo_q    <= (outCnt_q == 8'd127) ? 1'b0 : outReg_q[BLOCK_BITS-2];
                            outReg_q <= {outReg_q[BLOCK_BITS-3:0], 1'b0};
                            outCnt_q <= outCnt_q + 8'd1;
                        end else begin
                            sdo_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sdo_o             = sdo_q;
    assign done_o            = done_q;
    assign frame_err_o       = frameErr_q;
    assign core_start_o      = coreStart_q;
    assign core_cyphertext_o = coreCt_q;
    assign core_key_o        = coreKey_q;

endmodule
